// File: rtl/bus_port_pkg.sv
// Shared types and helpers for the bus port adapter.
//   ADDR_W        : width of the destination address field
//   BROADCAST_DEF : default broadcast destination
//   get_dest()    : extract the destination address from a packet
//   sat_inc8()    : saturating 8-bit increment used by the event counters
package bus_port_pkg;

  localparam int unsigned ADDR_W        = 8;
  localparam logic [ADDR_W-1:0] BROADCAST_DEF = 8'hFF;
  // Widest packet get_dest() accepts; callers zero-extend into this.
  localparam int unsigned PKT_MAX_W     = 256;

  // Destination lives in the top ADDR_W bits of a pkt_w-bit packet.
  function automatic logic [ADDR_W-1:0] get_dest(input logic [PKT_MAX_W-1:0] pkt,
                                                 input int unsigned       pkt_w);
    return ADDR_W'(pkt >> (pkt_w - ADDR_W));
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/bus_port_fifo_sync_fifo.sv
// First-word-fall-through synchronous FIFO, any depth >= 2.
//   clk, reset (async active-low)
//   wr_en/wr_data : write request, ignored while full
//   rd_en/rd_data : read request, ignored while empty; rd_data is the head (0 when empty)
//   full, empty, count : occupancy, all from registered state
module sync_fifo #(
  parameter int unsigned width = 16,
  parameter int unsigned depth = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         wr_en,
  input  logic [width-1:0]             wr_data,
  input  logic                         rd_en,
  output logic [width-1:0]             rd_data,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(depth+1)-1:0]   count
);

  localparam int unsigned PW = $clog2(depth);
  localparam int unsigned CW = $clog2(depth+1);

  logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [width-1:0] mem_q [depth];
  logic             do_wr, do_rd;

  // Explicit wrap so non-power-of-2 depths work.
  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(depth-1)) ? '0 : p + PW'(1);
  endfunction

  assign full  = (count_q == CW'(depth));
  assign empty = (count_q == '0);
  assign count = count_q;

  // Full/empty are the registered flags, so a read in the same cycle never
  // frees room for a write.
  assign do_wr = wr_en && !full;
  assign do_rd = rd_en && !empty;

  always_comb begin
    wr_ptr_d = do_wr ? next_ptr(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = do_rd ? next_ptr(rd_ptr_q) : rd_ptr_q;
    count_d  = count_q;
    if (do_wr && !do_rd)      count_d = count_q + CW'(1);
    else if (do_rd && !do_wr) count_d = count_q - CW'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: the head is masked to 0 while empty.
  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q] <= wr_data;
  end

  assign rd_data = empty ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/bus_port_fifo.sv
// Per-slot bus port adapter: TX FIFO toward the bus, RX FIFO toward the device.
//   TX : tx_valid/tx_data/tx_ready from device -> pndng/D_pop/pop to bus, tx_count
//   RX : push/D_push from bus -> rx_valid/rx_data/rx_ready to device
//   rx_drop_cnt  : saturating count of pushes lost to a full RX FIFO
//   misroute_cnt : saturating count of pushes not addressed to this port
// Optional destination filtering is enabled by defining BUS_PORT_ADDR_CHECK_EN;
// without it every push is accepted and misroute_cnt reads 0.
module bus_port_fifo import bus_port_pkg::*; #(
  parameter int unsigned       pckg_sz   = 16,
  parameter int unsigned       fifo_size = 8,
  parameter logic [ADDR_W-1:0] id        = 8'd0,
  parameter logic [ADDR_W-1:0] broadcast = BROADCAST_DEF
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           tx_valid,
  input  logic [pckg_sz-1:0]             tx_data,
  output logic                           tx_ready,
  output logic                           pndng,
  output logic [pckg_sz-1:0]             D_pop,
  input  logic                           pop,
  input  logic                           push,
  input  logic [pckg_sz-1:0]             D_push,
  output logic                           rx_valid,
  output logic [pckg_sz-1:0]             rx_data,
  input  logic                           rx_ready,
  output logic [$clog2(fifo_size+1)-1:0] tx_count,
  output logic [7:0]                     rx_drop_cnt,
  output logic [7:0]                     misroute_cnt
);

  localparam int unsigned CW = $clog2(fifo_size+1);

  logic          tx_full, tx_empty, rx_full, rx_empty;
  logic [CW-1:0] rx_count_unused;  // RX occupancy is not exported
  logic          addr_hit, addr_ok, rx_wr;
  logic [7:0]    drop_q, drop_d;

  // ---------------- TX path ----------------
  sync_fifo #(.width(pckg_sz), .depth(fifo_size)) u_tx_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (tx_valid),
    .wr_data (tx_data),
    .rd_en   (pop),
    .rd_data (D_pop),
    .full    (tx_full),
    .empty   (tx_empty),
    .count   (tx_count)
  );

  assign tx_ready = !tx_full;
  assign pndng    = !tx_empty;

  // ---------------- RX path ----------------
  assign addr_hit = (get_dest(PKT_MAX_W'(D_push), pckg_sz) == id) ||
                    (get_dest(PKT_MAX_W'(D_push), pckg_sz) == broadcast);

`ifdef BUS_PORT_ADDR_CHECK_EN
  logic [7:0] misroute_q, misroute_d;

  assign addr_ok = addr_hit;

  always_comb begin
    misroute_d = misroute_q;
    if (push && !addr_ok) misroute_d = sat_inc8(misroute_q);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) misroute_q <= '0;
    else        misroute_q <= misroute_d;
  end

  assign misroute_cnt = misroute_q;
`else
  // Unfiltered build: every push counts as addressed here.
  assign addr_ok      = addr_hit | 1'b1;
  assign misroute_cnt = '0;
`endif

  // Misrouted pushes never reach the full check, so they are never drops.
  assign rx_wr = push && addr_ok;

  sync_fifo #(.width(pckg_sz), .depth(fifo_size)) u_rx_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (rx_wr),
    .wr_data (D_push),
    .rd_en   (rx_ready),
    .rd_data (rx_data),
    .full    (rx_full),
    .empty   (rx_empty),
    .count   (rx_count_unused)
  );

  assign rx_valid = !rx_empty;

  // Full is the registered flag: a same-cycle device read does not save the push.
  always_comb begin
    drop_d = drop_q;
    if (rx_wr && rx_full) drop_d = sat_inc8(drop_q);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) drop_q <= '0;
    else        drop_q <= drop_d;
  end

  assign rx_drop_cnt = drop_q;

endmodule

// File: tb/tb_bus_port_fifo.sv
module tb_bus_port_fifo;

  localparam int W = 16;
`ifdef BUS_PORT_ADDR_CHECK_EN
  localparam bit ADDR_CHK = 1'b1;
`else
  localparam bit ADDR_CHK = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  // Index 0: depth 8, index 1: depth 5 (non-power-of-2 wrap). Both id=2.
  logic         tx_valid[2], pop[2], push[2], rx_ready[2];
  logic [W-1:0] tx_data[2], D_push[2], D_pop[2], rx_data[2];
  logic         tx_ready[2], pndng[2], rx_valid[2];
  logic [7:0]   rx_drop_cnt[2], misroute_cnt[2];
  logic [3:0]   tx_count0;
  logic [2:0]   tx_count1;

  bus_port_fifo #(.pckg_sz(W), .fifo_size(8), .id(8'd2), .broadcast(8'hFF)) u_dut0 (
    .clk(clk), .reset(reset), .tx_valid(tx_valid[0]), .tx_data(tx_data[0]),
    .tx_ready(tx_ready[0]), .pndng(pndng[0]), .D_pop(D_pop[0]), .pop(pop[0]),
    .push(push[0]), .D_push(D_push[0]), .rx_valid(rx_valid[0]), .rx_data(rx_data[0]),
    .rx_ready(rx_ready[0]), .tx_count(tx_count0), .rx_drop_cnt(rx_drop_cnt[0]),
    .misroute_cnt(misroute_cnt[0]));

  bus_port_fifo #(.pckg_sz(W), .fifo_size(5), .id(8'd2), .broadcast(8'hFF)) u_dut1 (
    .clk(clk), .reset(reset), .tx_valid(tx_valid[1]), .tx_data(tx_data[1]),
    .tx_ready(tx_ready[1]), .pndng(pndng[1]), .D_pop(D_pop[1]), .pop(pop[1]),
    .push(push[1]), .D_push(D_push[1]), .rx_valid(rx_valid[1]), .rx_data(rx_data[1]),
    .rx_ready(rx_ready[1]), .tx_count(tx_count1), .rx_drop_cnt(rx_drop_cnt[1]),
    .misroute_cnt(misroute_cnt[1]));

  int total = 0;
  int bad   = 0;
  bit run_cmp = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [W-1:0] txq[2][$];
  logic [W-1:0] rxq[2][$];
  int           drops[2] = '{0, 0};
  int           mis[2]   = '{0, 0};

  function automatic int dep(input int k);
    return (k == 0) ? 8 : 5;
  endfunction

  always @(negedge reset) begin
    for (int k = 0; k < 2; k++) begin
      txq[k].delete();
      rxq[k].delete();
      drops[k] = 0;
      mis[k]   = 0;
    end
  end

  always @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < 2; k++) begin
        bit tx_full, rx_full, ok;
        tx_full = (txq[k].size() == dep(k));
        if (pop[k] && txq[k].size() > 0) void'(txq[k].pop_front());
        if (tx_valid[k] && !tx_full) txq[k].push_back(tx_data[k]);
        rx_full = (rxq[k].size() == dep(k));
        if (rx_ready[k] && rxq[k].size() > 0) void'(rxq[k].pop_front());
        if (push[k]) begin
          ok = !ADDR_CHK || D_push[k][15:8] == 8'h02 || D_push[k][15:8] == 8'hFF;
          if (!ok) begin
            if (mis[k] < 255) mis[k]++;
          end else if (rx_full) begin
            if (drops[k] < 255) drops[k]++;
          end else begin
            rxq[k].push_back(D_push[k]);
          end
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (run_cmp) begin
      for (int k = 0; k < 2; k++) begin
        int cnt;
        cnt = (k == 0) ? int'(tx_count0) : int'(tx_count1);
        chk($sformatf("pndng[%0d]", k), 32'(pndng[k]), 32'(txq[k].size() != 0));
        chk($sformatf("D_pop[%0d]", k), 32'(D_pop[k]),
            (txq[k].size() != 0) ? 32'(txq[k][0]) : 32'd0);
        chk($sformatf("tx_ready[%0d]", k), 32'(tx_ready[k]), 32'(txq[k].size() != dep(k)));
        chk($sformatf("tx_count[%0d]", k), 32'(cnt), 32'(txq[k].size()));
        chk($sformatf("rx_valid[%0d]", k), 32'(rx_valid[k]), 32'(rxq[k].size() != 0));
        chk($sformatf("rx_data[%0d]", k), 32'(rx_data[k]),
            (rxq[k].size() != 0) ? 32'(rxq[k][0]) : 32'd0);
        chk($sformatf("rx_drop_cnt[%0d]", k), 32'(rx_drop_cnt[k]), 32'(drops[k]));
        chk($sformatf("misroute_cnt[%0d]", k), 32'(misroute_cnt[k]), 32'(mis[k]));
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0] dests[3];
    int wr_pct;
    dests[0] = 8'h02; dests[1] = 8'hFF; dests[2] = 8'h05;
    for (int k = 0; k < 2; k++) begin
      tx_valid[k] = 0; pop[k] = 0; push[k] = 0; rx_ready[k] = 0;
      tx_data[k] = '0; D_push[k] = '0;
    end
    #1 reset = 1'b0;
    run_cmp = 1'b1;
    cyc(); cyc();
    chk("rst_pndng", 32'(pndng[0]), 32'd0);
    chk("rst_tx_ready", 32'(tx_ready[0]), 32'd1);
    chk("rst_tx_count", 32'(tx_count0), 32'd0);
    chk("rst_D_pop", 32'(D_pop[0]), 32'd0);
    chk("rst_rx_valid", 32'(rx_valid[0]), 32'd0);
    chk("rst_rx_data", 32'(rx_data[0]), 32'd0);
    reset = 1'b1;
    cyc();

    // Basic TX
    tx_valid[0] = 1; tx_data[0] = 16'h3A5C; cyc();
    chk("basic_pndng", 32'(pndng[0]), 32'd1);
    chk("basic_head0", 32'(D_pop[0]), 32'h3A5C);
    tx_data[0] = 16'h1111; cyc(); tx_valid[0] = 0;
    chk("basic_hold", 32'(D_pop[0]), 32'h3A5C);
    pop[0] = 1; cyc(); pop[0] = 0;
    chk("basic_head1", 32'(D_pop[0]), 32'h1111);
    pop[0] = 1; cyc(); pop[0] = 0;
    chk("basic_empty", 32'(pndng[0]), 32'd0);

    // TX full, write blocked while pop arrives at full
    tx_valid[0] = 1;
    for (int i = 0; i < 8; i++) begin
      tx_data[0] = 16'hA000 + 16'(i); cyc();
    end
    chk("full_count", 32'(tx_count0), 32'd8);
    chk("full_ready", 32'(tx_ready[0]), 32'd0);
    tx_data[0] = 16'hA008; cyc();
    chk("full_9th_ignored", 32'(tx_count0), 32'd8);
    pop[0] = 1; cyc(); pop[0] = 0;
    chk("full_pop_no_wr", 32'(tx_count0), 32'd7);
    chk("full_ready_back", 32'(tx_ready[0]), 32'd1);
    cyc(); tx_valid[0] = 0;
    chk("full_refill", 32'(tx_count0), 32'd8);
    for (int i = 1; i <= 8; i++) begin
      chk("full_order", 32'(D_pop[0]), 32'hA000 + 32'(i));
      pop[0] = 1; cyc(); pop[0] = 0;
    end
    chk("full_drained", 32'(pndng[0]), 32'd0);

    // RX overflow
    push[0] = 1;
    for (int i = 0; i < 10; i++) begin
      D_push[0] = 16'h0200 + 16'(i); cyc();
    end
    push[0] = 0;
    chk("rx_drops", 32'(rx_drop_cnt[0]), 32'd2);
    for (int i = 0; i < 8; i++) begin
      chk("rx_order", 32'(rx_data[0]), 32'h0200 + 32'(i));
      rx_ready[0] = 1; cyc(); rx_ready[0] = 0;
    end
    chk("rx_drained", 32'(rx_valid[0]), 32'd0);

    // Pop while empty, then async reset mid-cycle
    pop[0] = 1; cyc(); pop[0] = 0;
    chk("pop_empty_count", 32'(tx_count0), 32'd0);
    tx_valid[0] = 1;
    for (int i = 0; i < 3; i++) begin
      tx_data[0] = 16'hB000 + 16'(i); cyc();
    end
    tx_valid[0] = 0;
    chk("pre_rst_count", 32'(tx_count0), 32'd3);
    #1 reset = 1'b0;
    #1;
    chk("async_rst_pndng", 32'(pndng[0]), 32'd0);
    chk("async_rst_count", 32'(tx_count0), 32'd0);
    chk("async_rst_drops", 32'(rx_drop_cnt[0]), 32'd0);
    cyc();
    reset = 1'b1;
    cyc();

    // Address filtering
    push[0] = 1;
    D_push[0] = 16'h0201; cyc();
    D_push[0] = 16'hFF02; cyc();
    D_push[0] = 16'h0503; cyc();
    push[0] = 0;
    chk("addr_head0", 32'(rx_data[0]), 32'h0201);
    rx_ready[0] = 1; cyc();
    chk("addr_head1", 32'(rx_data[0]), 32'hFF02);
    cyc();
`ifdef BUS_PORT_ADDR_CHECK_EN
    rx_ready[0] = 0;
    chk("addr_filtered_empty", 32'(rx_valid[0]), 32'd0);
    chk("addr_misroute", 32'(misroute_cnt[0]), 32'd1);
`else
    chk("addr_head2", 32'(rx_data[0]), 32'h0503);
    cyc(); rx_ready[0] = 0;
    chk("addr_all_queued_empty", 32'(rx_valid[0]), 32'd0);
    chk("addr_misroute", 32'(misroute_cnt[0]), 32'd0);
`endif

    // Randomized traffic on both ports with shifting write/read bias
    for (int n = 0; n < 600; n++) begin
      if (n % 100 == 0) wr_pct = (n % 300 == 0) ? 75 : ((n % 300 == 100) ? 25 : 50);
      for (int k = 0; k < 2; k++) begin
        tx_valid[k] = ($urandom_range(0, 99) < wr_pct);
        tx_data[k]  = 16'($urandom);
        pop[k]      = ($urandom_range(0, 99) < 100 - wr_pct);
        push[k]     = ($urandom_range(0, 99) < wr_pct);
        D_push[k]   = {dests[$urandom_range(0, 2)], 8'($urandom)};
        rx_ready[k] = ($urandom_range(0, 99) < 100 - wr_pct);
      end
      cyc();
    end
    for (int k = 0; k < 2; k++) begin
      tx_valid[k] = 0; pop[k] = 0; push[k] = 0; rx_ready[k] = 0;
    end
    cyc(); cyc();
    @(negedge clk);
    #1 run_cmp = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
